grn_node_lut: RTL
=================

# grn_node_lut

Parametrised Boolean-network node for the GRN simulation fabric, and the successor to the fixed-equation two-copy node. The node holds LANES independent state copies (trajectories) of one gene. Every lane evaluates the same runtime-programmable truth table over K regulator inputs. Each lane has its own update divider, so tortoise/hare-style attractor search (slow lane every 2nd pulse, fast lane every pulse) is one configuration among many. Per-lane change strobes and saturating toggle counters feed the attractor/oscillation detector.

## Interface
- K, 4: regulator inputs per lane; truth table is 2^K bits
- LANES, 2: independent state copies
- DIV_W, 4: width of per-lane divider value
- CNT_W, 16: width of per-lane toggle counter
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- reset_nos  in  1  synchronous reload of all lanes from init_state
- init_state  in  LANES  reload value, bit l → lane l
- start  in  LANES  per-lane step pulse
- div  in  LANES*DIV_W  lane l slice [l*DIV_W +: DIV_W]; lane evaluates on every (div_l+1)-th start pulse
- in_s  in  LANES*K  lane l regulator vector [l*K +: K]
- lut_we  in  1  truth-table write enable
- lut_data  in  2^K  truth-table write data
- s  out  LANES  current lane states
- changed  out  LANES  one-cycle pulse: lane value flipped on its last update
- tog_cnt  out  LANES*CNT_W  saturating per-lane flip count

## Operation
- Next state of lane l is lut[in_s_l]. in_s_l[0] is the LSB of the index.
- Per-lane phase counter ph_l:
  - reset_nos sets ph_l = 0.
  - On start_l with ph_l == 0: evaluate, then ph_l ← div_l.
  - On start_l with ph_l != 0: no evaluation, ph_l ← ph_l − 1.
  - div_l = 0 means update every pulse. div_l = 1 gives the legacy slow copy: first pulse after reset_nos evaluates, then every other pulse.
- div_l is sampled only when ph_l is reloaded. A change mid-count takes effect after the current count expires.
- On evaluation: s_l ← next. changed_l ← (next != s_l). If flipped, tog_cnt_l increments, saturating at 2^CNT_W−1.
- reset_nos:
  - s ← init_state; ph, changed, tog_cnt ← 0.
  - Has priority over start in the same cycle.
  - Does not touch the LUT.
- lut_we: lut ← lut_data. An evaluation in the same cycle uses the old table.
- Lanes are fully independent. Simultaneous starts on all lanes are legal.
- rst low, asynchronously: s, changed, ph, tog_cnt, lut all 0. Outputs stay 0 until first reset_nos or evaluation after rst deasserts.

## Timing
- Latency: s_l and changed_l update on the edge that samples start_l. Both are visible the following cycle.
- changed_l is high for exactly one cycle per flipping evaluation. It is 0 on non-evaluating pulses and on idle cycles.
- A start pulse held high for N cycles counts as N pulses.
- No backpressure and no busy: one evaluation per lane per cycle is sustained.
- Reset mid-operation: asynchronous assertion clears everything immediately. There is no partial update.

## Structure
- Package grn_pkg:
  - lane-slice index helpers
  - saturating-increment function
  - LUT index width constant
- Sub-module grn_lane (one per lane, generate loop) contains phase counter, state bit, changed and toggle counter.
- Shared LUT register and lookup mux sit in the top level.

## Test plan
- **Legacy equivalence:** K=4, lut=16'hFFEA (a | b&c | d, index bits [0]=a, [1]=b, [2]=c, [3]=d), div={1,0}, init=0, continuous start=2'b11, in_s=4'b0001 → lane1 s=1 after 1st pulse; lane0 s=1 after 1st pulse, then holds through pulses 2–4 with updates only on pulses 1, 3.
- **Divider:**
  - div_0=3, 8 start pulses, LUT toggles s (lut bit equals ~s via feedback input) → exactly 2 evaluations, s flips twice, changed pulses on pulses 1 and 5.
  - Change div to 0 during count → new value used only after reload.
- **Priority:** reset_nos and start asserted in the same cycle, init=2'b10 → s=2'b10, changed=0, tog_cnt=0.
- **LUT write race:**
  - lut_we with 16'hFFFF in the same cycle as evaluation under lut=0 → s=0.
  - Next evaluation → s=1.
- **Saturation:** CNT_W=3, oscillating lane for 10 evaluations → tog_cnt stops at 7; changed still pulses every evaluation.
- **Async reset:** assert rst low mid-run, between edges → s, changed, tog_cnt read 0 before the next clk edge. LUT reads back 0: all-ones input yields s=0 after reset_nos init=0 and one pulse.

Source files
------------

// File: rtl/grn_pkg.sv
// Shared constants and helpers for the GRN node fabric.
package grn_pkg;
  localparam int LUT_K = 4;

  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] mx;
    mx = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= mx) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/grn_lane.sv
// One trajectory of the node: phase divider, state bit, change strobe, toggle counter.
module grn_lane
  import grn_pkg::*;
#(
  parameter int DIV_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reset_nos,
  input  logic             init,
  input  logic             start,
  input  logic [DIV_W-1:0] div,
  input  logic             nxt,
  output logic             s,
  output logic             changed,
  output logic [CNT_W-1:0] tog_cnt
);
  logic [DIV_W-1:0] ph;
  logic [31:0]      cnt_inc;

  assign cnt_inc = sat_inc(32'(tog_cnt), CNT_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s       <= 1'b0;
      changed <= 1'b0;
      ph      <= '0;
      tog_cnt <= '0;
    end else if (reset_nos) begin
      s       <= init;
      changed <= 1'b0;
      ph      <= '0;
      tog_cnt <= '0;
    end else if (start) begin
      if (ph == '0) begin
        // div is only sampled here, so mid-count changes wait for the reload
        s       <= nxt;
        changed <= (nxt != s);
        ph      <= div;
        if (nxt != s) tog_cnt <= cnt_inc[CNT_W-1:0];
      end else begin
        changed <= 1'b0;
        ph      <= ph - 1'b1;
      end
    end else begin
      changed <= 1'b0;
    end
  end
endmodule

// File: rtl/grn_node_lut.sv
// Boolean-network node: shared programmable truth table feeding LANES independent lanes.
module grn_node_lut
  import grn_pkg::*;
#(
  parameter int K     = LUT_K,
  parameter int LANES = 2,
  parameter int DIV_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reset_nos,
  input  logic [LANES-1:0]       init_state,
  input  logic [LANES-1:0]       start,
  input  logic [LANES*DIV_W-1:0] div,
  input  logic [LANES*K-1:0]     in_s,
  input  logic                   lut_we,
  input  logic [(1<<K)-1:0]      lut_data,
  output logic [LANES-1:0]       s,
  output logic [LANES-1:0]       changed,
  output logic [LANES*CNT_W-1:0] tog_cnt
);
  logic [(1<<K)-1:0] lut;

  // Lanes read the pre-write table on the same edge as a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        lut <= '0;
    else if (lut_we) lut <= lut_data;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam int KLO = lane_lo(l, K);
    localparam int DLO = lane_lo(l, DIV_W);
    localparam int CLO = lane_lo(l, CNT_W);

    logic nxt;
    assign nxt = lut[in_s[KLO +: K]];

    grn_lane #(.DIV_W(DIV_W), .CNT_W(CNT_W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .reset_nos(reset_nos),
      .init     (init_state[l]),
      .start    (start[l]),
      .div      (div[DLO +: DIV_W]),
      .nxt      (nxt),
      .s        (s[l]),
      .changed  (changed[l]),
      .tog_cnt  (tog_cnt[CLO +: CNT_W])
    );
  end
endmodule
